// File: rtl/i2c_byte_master_pkg.sv
// Shared types and constants for the single-byte I2C master.
// Optional clock stretching is enabled by defining I2C_STRETCH_EN.
package i2c_byte_master_pkg;

    localparam int unsigned DEF_CLK_DIV = 4;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StStart   = 4'd1,
        StAddr    = 4'd2,
        StAddrAck = 4'd3,
        StWdata   = 4'd4,
        StWack    = 4'd5,
        StRdata   = 4'd6,
        StMnack   = 4'd7,
        StStop    = 4'd8,
        StDone    = 4'd9
    } state_e;

    // Bus levels for a given state and quarter-phase: returns {scl, sda_oe}.
    // tx_bit is the data bit currently being driven (only used in ADDR/WDATA).
    function automatic logic [1:0] bus_drive(state_e st, logic [1:0] ph, logic tx_bit);
        logic scl;
        logic oe;
        scl = 1'b1;
        oe  = 1'b0;
        unique case (st)
            StStart: begin
                // SDA falls while SCL is high, then SCL falls
                scl = (ph != 2'd3);
                oe  = (ph != 2'd0);
            end
            StAddr, StWdata: begin
                scl = (ph == 2'd1) || (ph == 2'd2);
                oe  = ~tx_bit;
            end
            StAddrAck, StWack, StRdata, StMnack: begin
                scl = (ph == 2'd1) || (ph == 2'd2);
                oe  = 1'b0;
            end
            StStop: begin
                // SDA held low while SCL rises, then released with SCL high
                scl = (ph != 2'd0);
                oe  = (ph != 2'd3);
            end
            default: begin
                scl = 1'b1;
                oe  = 1'b0;
            end
        endcase
        return {scl, oe};
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit prescaler for the I2C master: counts 0..CLK_DIV-1 while enabled
// and emits a one-cycle tick on the last count. hold_i freezes the count.
module i2c_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run;

    assign run    = en_i && !hold_i;
    assign tick_o = run && (cnt_q == CntMax);

    // Next count: synchronous clear wins, otherwise wrap at CntMax.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Define I2C_STRETCH_EN to let a target stretch SCL during the high phase.
module i2c_byte_master
    import i2c_byte_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned ADDR_W  = 7
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_rw,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_nack,
    output logic              sda_oe,
    input  logic              sda_i,
    output logic              scl_o,
    input  logic              scl_i
);

    state_e     state_q, state_d;
    logic [1:0] ph_q, ph_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rw_q, rw_d;
    logic       nack_q, nack_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_nack_q, rsp_nack_d;
    logic       scl_q, scl_d;
    logic       sda_oe_q, sda_oe_d;

    logic accept;
    logic busy;
    logic tick;
    logic hold;

    // Ready stays low through the response cycle.
    assign req_ready = (state_q == StIdle) && !rsp_valid_q;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != StIdle);

`ifdef I2C_STRETCH_EN
    // Freeze the quarter-bit timer while SCL is released but held low by a target.
    assign hold = busy && (ph_q == 2'd1) && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign hold         = 1'b0;
`endif

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i  (PCLK),
        .rst_ni (PRESETn),
        .en_i   (busy),
        .clr_i  (accept),
        .hold_i (hold),
        .tick_o (tick)
    );

    // Next-state, datapath and registered bus levels.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        nack_d      = nack_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nack_d  = rsp_nack_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                    ph_d    = 2'd0;
                    bit_d   = 3'd0;
                    shift_d = 8'({req_addr, req_rw});
                    wdata_d = req_wdata;
                    rw_d    = req_rw;
                    nack_d  = 1'b0;
                end
            end
            StDone: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                rsp_nack_d  = nack_q;
                // Only a completed read returns data; everything else reports zero.
                rsp_rdata_d = (rw_q == I2C_RD && !nack_q) ? shift_q : 8'h00;
            end
            default: begin
                if (tick) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd2) begin
                        // End of SCL-high phase: sample the line.
                        case (state_q)
                            StAddrAck, StWack: nack_d = nack_q | sda_i;
                            StRdata:           shift_d = {shift_q[6:0], sda_i};
                            default: ;
                        endcase
                    end
                    if (ph_q == 2'd3) begin
                        // End of bit slot.
                        case (state_q)
                            StStart: begin
                                state_d = StAddr;
                                bit_d   = 3'd0;
                            end
                            StAddr: begin
                                shift_d = {shift_q[6:0], 1'b0};
                                bit_d   = bit_q + 3'd1;
                                if (bit_q == 3'd7) state_d = StAddrAck;
                            end
                            StAddrAck: begin
                                bit_d = 3'd0;
                                if (nack_q) begin
                                    state_d = StStop;
                                end else if (rw_q == I2C_RD) begin
                                    state_d = StRdata;
                                end else begin
                                    state_d = StWdata;
                                    shift_d = wdata_q;
                                end
                            end
                            StWdata: begin
                                shift_d = {shift_q[6:0], 1'b0};
                                bit_d   = bit_q + 3'd1;
                                if (bit_q == 3'd7) state_d = StWack;
                            end
                            StWack:  state_d = StStop;
                            StRdata: begin
                                bit_d = bit_q + 3'd1;
                                if (bit_q == 3'd7) state_d = StMnack;
                            end
                            StMnack: state_d = StStop;
                            StStop:  state_d = StDone;
                            default: state_d = StIdle;
                        endcase
                    end
                end
            end
        endcase

        {scl_d, sda_oe_d} = bus_drive(state_d, ph_d, shift_d[7]);
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            ph_q        <= 2'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            wdata_q     <= 8'h00;
            rw_q        <= I2C_WR;
            nack_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_nack_q  <= 1'b0;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            nack_q      <= nack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
            scl_q       <= scl_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_nack  = rsp_nack_q;
    assign scl_o     = scl_q;
    assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master with a bus-level I2C target model.
// The stretch sequence runs only when I2C_STRETCH_EN is defined.
`timescale 1ns/1ps
module tb_i2c_byte_master;

    localparam int unsigned CLK_DIV  = 4;
    localparam int          LAT_FULL = 80 * CLK_DIV + 2;
    localparam int          LAT_NACK = 44 * CLK_DIV + 2;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_wdata, rsp_rdata;
    logic       rsp_valid, rsp_nack, sda_oe, sda_i, scl_o, scl_i;

    logic pull          = 1'b0;
    logic stretch_force = 1'b0;

    assign sda_i = ~sda_oe & ~pull;
    assign scl_i = scl_o & ~stretch_force;

    i2c_byte_master #(
        .CLK_DIV (CLK_DIV),
        .ADDR_W  (7)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i),
        .scl_o     (scl_o),
        .scl_i     (scl_i)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Target model configuration (written by the main sequence only).
    logic       ack_addr = 1'b1;
    logic       ack_data = 1'b1;
    logic [7:0] rbyte    = 8'h00;
    int         stretch_len = 0;

    // Bus observations (written by the monitor only).
    logic bits [0:63];
    int   nbits     = 0;
    logic stop_seen = 1'b0;

    function automatic logic [7:0] byte_at(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = bits[base+i];
        return b;
    endfunction

    // What the target pulls for bit slot n (0-based, counted from START).
    function automatic logic slave_drive(input int n);
        if (n == 8) return ack_addr;
        if (!ack_addr) return 1'b0;
        if (n >= 9 && n <= 16) return bits[7] ? ~rbyte[16-n] : 1'b0;
        if (n == 17) return bits[7] ? 1'b0 : ack_data;
        return 1'b0;
    endfunction

    // Bus monitor and target model.
    initial begin
        logic prev_scl, prev_sda, line;
        int   force_left;
        prev_scl   = 1'b1;
        prev_sda   = 1'b1;
        force_left = 0;
        forever begin
            @(negedge PCLK);
            line = ~sda_oe & ~pull;
            if (!PRESETn) begin
                pull          = 1'b0;
                stretch_force = 1'b0;
                force_left    = 0;
                prev_scl      = 1'b1;
                prev_sda      = 1'b1;
            end else begin
                if (force_left > 0) begin
                    force_left--;
                    if (force_left == 0) stretch_force = 1'b0;
                end
                if (scl_o && prev_scl && prev_sda && !line) begin
                    nbits     = 0;
                    stop_seen = 1'b0;
                end else if (scl_o && prev_scl && !prev_sda && line) begin
                    stop_seen = 1'b1;
                end
                if (scl_o && !prev_scl) begin
                    if (nbits == 0 && stretch_len > 0) begin
                        stretch_force = 1'b1;
                        force_left    = stretch_len;
                    end
                    if (nbits < 64) bits[nbits] = line;
                    nbits++;
                end
                if (!scl_o && prev_scl) pull = slave_drive(nbits);
                prev_scl = scl_o;
                prev_sda = line;
            end
        end
    end

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic       ack_addr;
        logic       ack_data;
        logic [7:0] rbyte;
        logic       exp_nack;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    // Reference outcome from the protocol rules.
    function automatic vec_t ref_model(input vec_t v);
        vec_t r;
        r           = v;
        r.exp_nack  = !v.ack_addr || (!v.rw && !v.ack_data);
        r.exp_rdata = (v.rw && v.ack_addr) ? v.rbyte : 8'h00;
        r.exp_lat   = v.ack_addr ? LAT_FULL : LAT_NACK;
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input int extra_lat);
        int acc, lat, bad_ready;
        bit ok;
        ack_addr = v.ack_addr;
        ack_data = v.ack_data;
        rbyte    = v.rbyte;
        @(negedge PCLK);
        req_addr  = v.addr;
        req_rw    = v.rw;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge PCLK);
        end
        chk("accept", int'(ok), 1);
        if (!ok) begin req_valid = 1'b0; return; end
        acc       = cyc;
        ok        = 0;
        bad_ready = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge PCLK);
            req_valid = 1'b0;
            if (rsp_valid) begin ok = 1; break; end
            if (req_ready) bad_ready++;
        end
        chk("rsp_seen", int'(ok), 1);
        if (!ok) return;
        lat = cyc - acc;
        chk("latency", lat, v.exp_lat + extra_lat);
        chk("rsp_nack", int'(rsp_nack), int'(v.exp_nack));
        chk("rsp_rdata", int'(rsp_rdata), int'(v.exp_rdata));
        chk("ready_low_busy", bad_ready, 0);
        chk("addr_byte", int'(byte_at(0)), int'({v.addr, v.rw}));
        chk("bus_bits", nbits, v.ack_addr ? 19 : 10);
        chk("stop_seen", int'(stop_seen), 1);
        if (v.ack_addr) begin
            chk("data_byte", int'(byte_at(9)), int'(v.rw ? v.rbyte : v.wdata));
            if (v.rw) chk("master_nack", int'(bits[17]), 1);
        end
        @(negedge PCLK);
        chk("rsp_one_shot", int'(rsp_valid), 0);
    endtask

    vec_t tbl [$];

    initial begin
        vec_t v;
        int   acc1, rsp1, acc2, bad, n_rsp;
        bit   ok;

        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_rw    = 1'b0;
        req_wdata = '0;
        repeat (3) @(negedge PCLK);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_scl", int'(scl_o), 1);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("rst_ready_after", int'(req_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rdata", int'(rsp_rdata), 0);
        chk("rst_nack", int'(rsp_nack), 0);
        chk("rst_sda_oe", int'(sda_oe), 0);
        chk("rst_scl_after", int'(scl_o), 1);

        // Directed rows: addr, rw, wdata, ack_addr, ack_data, rbyte, exp_nack, exp_rdata, lat
        tbl.push_back('{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 322});
        tbl.push_back('{7'h50, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C, 322});
        tbl.push_back('{7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 178});
        tbl.push_back('{7'h2A, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 322});
        tbl.push_back('{7'h7F, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00, 178});
        for (int i = 0; i < 8; i++) begin
            v.addr     = 7'($urandom);
            v.rw       = 1'($urandom);
            v.wdata    = 8'($urandom);
            v.ack_addr = ($urandom_range(0, 3) != 0);
            v.ack_data = ($urandom_range(0, 3) != 0);
            v.rbyte    = 8'($urandom);
            tbl.push_back(ref_model(v));
        end
        foreach (tbl[i]) run_txn(tbl[i], 0);

        // Busy ignore: hold req_valid across a whole transaction.
        ack_addr = 1'b1;
        ack_data = 1'b1;
        @(negedge PCLK);
        req_addr  = 7'h11;
        req_rw    = 1'b0;
        req_wdata = 8'h5A;
        req_valid = 1'b1;
        chk("busy_ready_initial", int'(req_ready), 1);
        acc1 = cyc;
        @(negedge PCLK);
        req_addr  = 7'h22;
        req_wdata = 8'hC3;
        bad  = 0;
        ok   = 0;
        rsp1 = 0;
        for (int i = 0; i < 1000; i++) begin
            if (req_ready) bad++;
            if (rsp_valid) begin ok = 1; rsp1 = cyc; break; end
            @(negedge PCLK);
        end
        chk("busy_rsp_seen", int'(ok), 1);
        chk("busy_ready_low", bad, 0);
        chk("busy_latency", rsp1 - acc1, LAT_FULL);
        chk("busy_first_addr", int'(byte_at(0)), int'({7'h11, 1'b0}));
        @(negedge PCLK);
        chk("busy_ready_back", int'(req_ready), 1);
        acc2 = cyc;
        chk("busy_accept_gap", acc2 - rsp1, 1);
        @(negedge PCLK);
        req_valid = 1'b0;
        n_rsp = 0;
        for (int i = 0; i < 500; i++) begin
            if (rsp_valid) n_rsp++;
            @(negedge PCLK);
        end
        chk("busy_second_rsp_count", n_rsp, 1);
        chk("busy_second_addr", int'(byte_at(0)), int'({7'h22, 1'b0}));

        // Reset in the middle of the address byte.
        @(negedge PCLK);
        req_addr  = 7'h50;
        req_rw    = 1'b0;
        req_wdata = 8'hA5;
        req_valid = 1'b1;
        @(negedge PCLK);
        req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (sda_oe && !scl_o && nbits >= 1 && nbits < 8) begin ok = 1; break; end
            @(negedge PCLK);
        end
        chk("midaddr_reached", int'(ok), 1);
        #1 PRESETn = 1'b0;
        #1;
        chk("midrst_sda_oe", int'(sda_oe), 0);
        chk("midrst_scl", int'(scl_o), 1);
        chk("midrst_ready", int'(req_ready), 1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        n_rsp = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge PCLK);
            if (rsp_valid) n_rsp++;
        end
        chk("midrst_no_rsp", n_rsp, 0);

`ifdef I2C_STRETCH_EN
        // Target holds SCL low for 20 cycles in the first address bit.
        stretch_len = 20;
        run_txn('{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 322}, 20);
        stretch_len = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
